// File: rtl/mem_arbiter_if.sv
// Block-memory port bundle shared by both caches and the main memory side.
// master drives strobes/address/write data; slave answers with read data and busy.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
);
   logic                  read;
   logic                  write;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  busy;

   modport master (output read, write, address, write_data, input read_data, busy);
   modport slave  (input read, write, address, write_data, output read_data, busy);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising I-cache/D-cache block transfers onto one memory port.
// Latency: grant+issue+done add 3 cycles over memory busy; losing port stays busy until served.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  icache,
   mem_arbiter_if.slave  dcache,
   mem_arbiter_if.master mem
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } req_t;

   state_t                state, state_nxt;
   req_t                  req_q, req_nxt;
   logic                  grant, grant_nxt;
   logic                  last;
   logic                  mask_vld;
   logic                  mask;
   logic                  load;
   logic                  capture;
   logic                  active;
   logic                  req_i, req_d;
   logic                  elig_i, elig_d;
   logic [DATA_WIDTH-1:0] rdata_i, rdata_d;
   logic                  unused_icache;

   assign req_i = icache.read;
   assign req_d = dcache.read | dcache.write;

   // The port finished in the last DONE sits out exactly one IDLE cycle so its
   // still-asserted request is not mistaken for a new one.
   assign elig_i = req_i && !(mask_vld && !mask);
   assign elig_d = req_d && !(mask_vld && mask);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      req_nxt   = req_q;
      load      = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (elig_i || elig_d) begin
               load      = 1'b1;
               state_nxt = ISSUE;
               grant_nxt = (elig_i && elig_d) ? !last : elig_d;
               if (grant_nxt) begin
                  req_nxt.wr    = dcache.write;
                  req_nxt.addr  = dcache.address;
                  req_nxt.wdata = dcache.write_data;
               end else begin
                  req_nxt.wr    = 1'b0;
                  req_nxt.addr  = icache.address;
                  req_nxt.wdata = '0;
               end
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (!mem.busy) begin
               state_nxt = DONE;
               capture   = !req_q.wr;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= 1'b0;
         last     <= 1'b0;
         mask_vld <= 1'b0;
         mask     <= 1'b0;
         req_q    <= '0;
         rdata_i  <= '0;
         rdata_d  <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            grant <= grant_nxt;
            req_q <= req_nxt;
         end
         if (capture) begin
            if (grant) rdata_d <= mem.read_data;
            else       rdata_i <= mem.read_data;
         end
         if (state == DONE) begin
            last     <= grant;
            mask_vld <= 1'b1;
            mask     <= grant;
         end else if (state == IDLE) begin
            mask_vld <= 1'b0;
         end
      end
   end

   assign active         = (state == ISSUE) || (state == WAIT);
   assign mem.read       = active && !req_q.wr;
   assign mem.write      = active && req_q.wr;
   assign mem.address    = active ? req_q.addr  : '0;
   assign mem.write_data = active ? req_q.wdata : '0;

   assign icache.read_data = rdata_i;
   assign dcache.read_data = rdata_d;
   assign icache.busy      = req_i && !((state == DONE) && !grant);
   assign dcache.busy      = req_d && !((state == DONE) && grant);

   // Instruction port is read-only; its write lines are ignored.
   assign unused_icache = icache.write ^ (^icache.write_data);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural block memory of programmable busy length.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic reset;

   mem_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) ibus ();
   mem_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dbus ();
   mem_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) mbus ();

   mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .icache (ibus),
      .dcache (dbus),
      .mem    (mbus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem_arr [64];
   int          busy_len;
   int          cnt;
   bit          started;
   int          n_wr;
   int          n_vec  = 0;
   int          n_miss = 0;

   assign mbus.read_data = mem_arr[mbus.address];

   // Memory updates mid-cycle: busy rises in ISSUE and is seen high at busy_len WAIT edges.
   always @(negedge clk) begin
      if (reset) begin
         started   = 1'b0;
         cnt       = 0;
         mbus.busy = 1'b0;
      end else if (mbus.read || mbus.write) begin
         if (!started) begin
            started   = 1'b1;
            cnt       = busy_len + 1;
            mbus.busy = 1'b1;
         end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               mbus.busy = 1'b0;
               if (mbus.write) begin
                  mem_arr[mbus.address] = mbus.write_data;
                  n_wr = n_wr + 1;
               end
            end
         end
      end else begin
         started   = 1'b0;
         mbus.busy = 1'b0;
      end
   end

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy_low(input bit on_d, input string tag);
      for (int k = 0; k < 40; k++) begin
         if (!(on_d ? dbus.busy : ibus.busy)) break;
         tick();
      end
      check_vec(tag, on_d ? dbus.busy : ibus.busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      for (int a = 0; a < 64; a++) mem_arr[a] = 32'hA5A50000 + 32'(a);
      mem_arr[6'h15] = 32'hDEADBEEF;
      mem_arr[6'h01] = 32'h11110001;
      n_wr = 0;
      busy_len = 5;
      reset = 1'b1;
      ibus.read = 1'b1;  ibus.write = 1'b0;  ibus.address = 6'h15; ibus.write_data = '0;
      dbus.read = 1'b0;  dbus.write = 1'b0;  dbus.address = '0;    dbus.write_data = '0;

      // Reset with instruction request held
      for (int c = 0; c < 3; c++) begin
         tick();
         check_vec("rst_read_mem",  mbus.read, 0);
         check_vec("rst_write_mem", mbus.write, 0);
         check_vec("rst_rdata_i",   ibus.read_data, 0);
         check_vec("rst_busy_i",    ibus.busy, 1);
      end
      reset = 1'b0;
      check_vec("t1_idle_read_mem", mbus.read, 0);
      check_vec("t1_idle_busy_i", ibus.busy, 1);

      // Single I read, 5 busy cycles: DONE in cycle 8
      for (int c = 1; c <= 8; c++) begin
         tick();
         check_vec("t1_busy_i", ibus.busy, (c != 8));
         if (c == 1) begin
            check_vec("t1_issue_read", mbus.read, 1);
            check_vec("t1_issue_addr", mbus.address, 6'h15);
         end
         if (c == 8) begin
            check_vec("t1_rdata_i", ibus.read_data, 32'hDEADBEEF);
            check_vec("t1_rdata_d", dbus.read_data, 0);
            check_vec("t1_done_read", mbus.read, 0);
         end
      end
      tick();
      ibus.read = 1'b0;
      tick();
      check_vec("t1_no_regrant", mbus.read, 0);

      // Simultaneous I read and D write after reset: D wins the first tie
      reset = 1'b1;
      tick();
      tick();
      check_vec("t3_rst_rdata_i", ibus.read_data, 0);
      reset = 1'b0;
      busy_len = 2;
      ibus.read = 1'b1;  ibus.address = 6'h01;
      dbus.write = 1'b1; dbus.address = 6'h22; dbus.write_data = 32'h12345678;
      tick();
      check_vec("t3_write_mem", mbus.write, 1);
      check_vec("t3_read_mem",  mbus.read, 0);
      check_vec("t3_addr",      mbus.address, 6'h22);
      check_vec("t3_wdata",     mbus.write_data, 32'h12345678);
      check_vec("t3_busy_i_issue", ibus.busy, 1);
      wait_busy_low(1'b1, "t3_d_done");
      check_vec("t3_busy_i_done", ibus.busy, 1);
      tick();
      dbus.write = 1'b0;
      check_vec("t3_gap_read",  mbus.read, 0);
      check_vec("t3_gap_write", mbus.write, 0);
      check_vec("t3_gap_busy_i", ibus.busy, 1);
      tick();
      check_vec("t3_i_issue_read", mbus.read, 1);
      check_vec("t3_i_issue_addr", mbus.address, 6'h01);
      wait_busy_low(1'b0, "t3_i_done");
      check_vec("t3_rdata_i", ibus.read_data, 32'h11110001);
      check_vec("t3_rdata_d", dbus.read_data, 0);
      check_vec("t3_n_wr", n_wr, 1);
      check_vec("t3_mem_22", mem_arr[6'h22], 32'h12345678);
      tick();
      ibus.read = 1'b0;

      // Both ports requesting continuously: D, I, D, I, D
      busy_len = 1;
      ibus.read = 1'b1; ibus.address = 6'h31;
      dbus.read = 1'b1; dbus.address = 6'h30;
      for (int t = 0; t < 5; t++) begin
         k = 0;
         while (!mbus.read && k < 30) begin tick(); k++; end
         check_vec("t4_order", mbus.address, (t % 2 == 0) ? 6'h30 : 6'h31);
         k = 0;
         while (mbus.read && k < 30) begin tick(); k++; end
         check_vec("t4_strobe_end", mbus.read, 0);
         tick();
         if (t == 3) ibus.read = 1'b0;
         if (t == 4) dbus.read = 1'b0;
      end
      check_vec("t4_rdata_d", dbus.read_data, 32'hA5A50030);
      check_vec("t4_rdata_i", ibus.read_data, 32'hA5A50031);

      // Write-back then refill on the data port
      busy_len = 3;
      dbus.write = 1'b1; dbus.address = 6'h2A; dbus.write_data = 32'hCAFEF00D;
      wait_busy_low(1'b1, "t5_wb_done");
      check_vec("t5_wb_done_strobe", mbus.write, 0);
      tick();
      dbus.write = 1'b0; dbus.read = 1'b1; dbus.address = 6'h0A;
      check_vec("t5_gap1", mbus.read | mbus.write, 0);
      tick();
      check_vec("t5_mask_gap", mbus.read | mbus.write, 0);
      tick();
      check_vec("t5_refill_read",  mbus.read, 1);
      check_vec("t5_refill_write", mbus.write, 0);
      check_vec("t5_refill_addr",  mbus.address, 6'h0A);
      wait_busy_low(1'b1, "t5_refill_done");
      check_vec("t5_rdata_d", dbus.read_data, 32'hA5A5000A);
      check_vec("t5_rdata_i", ibus.read_data, 32'hA5A50031);
      check_vec("t5_n_wr", n_wr, 2);
      check_vec("t5_mem_2a", mem_arr[6'h2A], 32'hCAFEF00D);
      tick();
      dbus.read = 1'b0;

      // Reset in the third WAIT cycle of a D read
      tick();
      busy_len = 8;
      dbus.read = 1'b1; dbus.address = 6'h33;
      tick();
      check_vec("t6_issue", mbus.read, 1);
      tick();
      tick();
      tick();
      check_vec("t6_wait3", mbus.read, 1);
      reset = 1'b1;
      dbus.read = 1'b0;
      tick();
      check_vec("t6_rst_read",   mbus.read, 0);
      check_vec("t6_rst_write",  mbus.write, 0);
      check_vec("t6_rst_addr",   mbus.address, 0);
      check_vec("t6_rst_rdata_d", dbus.read_data, 0);
      check_vec("t6_rst_rdata_i", ibus.read_data, 0);
      reset = 1'b0;
      busy_len = 0;
      ibus.read = 1'b1; ibus.address = 6'h15;
      tick();
      check_vec("t6_new_issue", mbus.read, 1);
      check_vec("t6_new_addr",  mbus.address, 6'h15);
      check_vec("t6_new_busy_issue", ibus.busy, 1);
      tick();
      check_vec("t6_new_busy_wait", ibus.busy, 1);
      tick();
      check_vec("t6_new_busy_done", ibus.busy, 0);
      check_vec("t6_new_rdata_i", ibus.read_data, 32'hDEADBEEF);
      check_vec("t6_new_rdata_d", dbus.read_data, 0);
      tick();
      ibus.read = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single 32-bit-block main memory between the instruction cache and the data cache of the 8-bit CPU. Sits between both cache controllers and the data memory, presents each cache an interface identical to the memory port (READ/WRITE/ADDRESS/WRITE_DATA in, READ_DATA/BUSY out), and serialises block transfers with round-robin fairness. The instruction port is read-only; the data port carries both refills and dirty write-backs.

## Interface
- ADDR_WIDTH, 6, block address width (tag+index).
- DATA_WIDTH, 32, block width.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- READ_I  in  1  instruction-cache block read request.
- ADDRESS_I  in  ADDR_WIDTH  instruction-cache block address.
- READ_DATA_I  out  DATA_WIDTH  block returned to instruction cache.
- BUSY_I  out  1  instruction port busy.
- READ_D, WRITE_D  in  1  data-cache block read / write-back request.
- ADDRESS_D  in  ADDR_WIDTH  data-cache block address.
- WRITE_DATA_D  in  DATA_WIDTH  write-back block.
- READ_DATA_D  out  DATA_WIDTH  block returned to data cache.
- BUSY_D  out  1  data port busy.
- READ_MEM, WRITE_MEM  out  1  memory strobes.
- ADDRESS_MEM  out  ADDR_WIDTH  memory block address.
- WRITE_DATA_MEM  out  DATA_WIDTH  memory write block.
- READ_DATA_MEM  in  DATA_WIDTH  memory read block.
- BUSY_MEM  in  1  memory busy.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Registers: GRANT (0=I, 1=D), LAST (last served port), MASK (port served in previous DONE), latched ADDR/WDATA/OP.
- IDLE: eligible requests = asserted and not MASK. One eligible -> grant it. Both eligible -> grant port != LAST. None -> stay. On grant latch address, op (write if WRITE_D, else read; READ_D&WRITE_D together is treated as write), write data; go ISSUE. MASK clears on leaving IDLE's first cycle.
- ISSUE (exactly 1 cycle): drive READ_MEM/WRITE_MEM, ADDRESS_MEM, WRITE_DATA_MEM from latches; -> WAIT.
- WAIT: keep driving strobes; when BUSY_MEM==0 sampled -> DONE, and on a read capture READ_DATA_MEM into READ_DATA_I or READ_DATA_D (per GRANT). Memory must raise BUSY_MEM no later than the first WAIT cycle.
- DONE (1 cycle): strobes low; LAST<=GRANT; MASK<=GRANT; -> IDLE.
- BUSY_x = request_x asserted and not (state==DONE and GRANT==x). Combinational; the granted port's BUSY falls only in DONE, the waiting port stays busy throughout.
- Requesters hold request, address and write data stable while BUSY is high and drop the request at the edge ending DONE; MASK guarantees no re-grant of a still-asserted request in the following IDLE cycle.
- READ_DATA_x holds its last captured value; unaffected by writes or by the other port.
- Memory outputs outside ISSUE/WAIT: strobes 0, address and write data 0.

## Timing
- Reset (synchronous, sampled at CLK edge): state IDLE, GRANT=0, LAST=0 (so D wins first tie), MASK cleared, all memory outputs 0, READ_DATA_I/D = 0. BUSY_x follows its combinational rule (high if request asserted).
- Reset mid-transaction: aborts immediately at that edge; strobes 0 next cycle; no data captured; memory and caches are reset by the same signal.
- Latency, idle memory with B busy cycles (BUSY_MEM high for B WAIT cycles): request seen at edge 0 -> ISSUE cycle 1 -> WAIT cycles 2..B+2 -> DONE cycle B+3; BUSY_x low during cycle B+3. Fixed arbitration overhead 3 cycles.
- Contention: second requester waits the full first transaction plus the 1-cycle IDLE gap.
- Back-to-back same port (write-back then refill from data cache): second request accepted no earlier than 2 cycles after DONE (MASK cycle).

## Test plan
- Reset with READ_I=1 held -> READ_MEM=0, WRITE_MEM=0, READ_DATA_I=0, BUSY_I=1 throughout reset; grant starts the cycle after RESET falls.
- Single I read, ADDRESS_I=6'h15, memory 5-cycle busy returning 32'hDEADBEEF -> ADDRESS_MEM=6'h15 from ISSUE, BUSY_I low exactly in cycle 8, READ_DATA_I=32'hDEADBEEF, READ_DATA_D unchanged.
- Simultaneous READ_I (6'h01) and WRITE_D (6'h22, data 32'h12345678) after reset -> D served first (WRITE_MEM=1, WRITE_DATA_MEM=32'h12345678), BUSY_I stays 1, then I read issued after one IDLE cycle.
- Both ports requesting continuously for 4 transactions -> grant order D, I, D, I; no port granted twice consecutively.
- Data-cache write-back 6'h2A then refill 6'h0A on the same port -> two distinct transactions, no duplicate write, refill data lands only in READ_DATA_D.
- RESET asserted in third WAIT cycle of a D read -> strobes 0 next cycle, READ_DATA_D=0, state IDLE, new request served normally after reset.
